// File: rtl/imem_boot_sequencer.sv
// imem_boot_sequencer: loads a boot image from the serial word receiver into
// instruction memory and owns the processor reset line.
// Latency: word edge sampled in LOAD -> write strobe next cycle; a word that opens a
// load from HOLD/RUN/ERROR strobes one cycle later because it passes through LOAD first.
// Backpressure: none; the receiver is never stalled, so words must be >= 3 cycles apart.
// Ports: clock/reset (sync, active-high); rx_ready/rx_word/rx_addr from the receiver;
// boot_req forces a load; imem_wEn/imem_waddr/imem_wdata drive the ROM write port;
// cpu_reset holds the CPU; words_loaded/busy/error are status.
// Optional feature macro: BOOT_CHECKSUM_EN (final word of a load checked as XOR checksum).
module imem_boot_sequencer #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int HOLD_CYCLES    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx_ready,
    input  logic [31:0]           rx_word,
    input  logic [ADDR_WIDTH-1:0] rx_addr,
    input  logic                  boot_req,
    output logic                  cpu_reset,
    output logic                  imem_wEn,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  busy,
    output logic                  error
);
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [IW-1:0]       IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0]       HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] WL_MAX    = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        RUN   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_ready_q;
    logic            new_word;
    logic            pend;
    logic            enter_load;
    logic            accept;
    logic            chk_fail;
    logic [IW-1:0]   idle_cnt;
    logic [HW-1:0]   hold_cnt;

    // A level held high counts once: only the rising edge is a word.
    assign new_word = rx_ready & ~rx_ready_q;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] chk_xor;

    always_ff @(posedge clock) begin
        if (reset) begin
            chk_xor <= '0;
        end else if (enter_load) begin
            chk_xor <= '0;
        end else if (state == WRITE) begin
            chk_xor <= chk_xor ^ imem_wdata;
        end
    end

    // XOR over all words including the final one is zero exactly when the final
    // word equals the XOR of the words before it. An empty load leaves it at zero.
    assign chk_fail = (chk_xor != 32'd0);
    assign error    = (state == ERROR);
`else
    assign chk_fail = 1'b0;
    assign error    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_reset  = 1'b1;
        imem_wEn   = 1'b0;
        busy       = 1'b0;
        enter_load = 1'b0;
        accept     = 1'b0;
        case (state)
            HOLD: begin
                if (new_word || boot_req) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cpu_reset = 1'b0;
                if (new_word || boot_req) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                busy = 1'b1;
                // A word wins over the timeout when both land in the same cycle.
                if (new_word || pend) begin
                    accept    = 1'b1;
                    state_nxt = WRITE;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt = chk_fail ? ERROR : HOLD;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                imem_wEn  = 1'b1;
                state_nxt = LOAD;
            end
            ERROR: begin
                if (new_word || boot_req) begin
                    state_nxt  = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_ready_q   <= 1'b0;
            pend         <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
            idle_cnt     <= '0;
            hold_cnt     <= '0;
        end else begin
            rx_ready_q <= rx_ready;

            // Every word edge is captured immediately. Outside LOAD (opening a load,
            // or arriving during WRITE) it is parked and written on the next LOAD
            // cycle; the write-port registers only change after the strobe cycle.
            if (new_word) begin
                imem_waddr <= rx_addr;
                imem_wdata <= rx_word;
            end
            // Every state that can see a parked word moves to LOAD next, which
            // always consumes it, so a one-cycle flag is enough.
            pend <= new_word && (state != LOAD);

            if (enter_load) begin
                words_loaded <= '0;
            end else if (accept && (words_loaded != WL_MAX)) begin
                words_loaded <= words_loaded + 1'b1;
            end

            // Idle count runs through WRITE too, so the load closes TIMEOUT_CYCLES
            // after the last strobe cycle.
            if (enter_load || accept || !((state_nxt == LOAD) || (state_nxt == WRITE))) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if ((state == HOLD) && (state_nxt == HOLD)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
module tb_imem_boot_sequencer;
    localparam int AW = 12;
    localparam int TO = 8;
    localparam int HC = 16;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx_ready = 1'b0;
    logic [31:0]   rx_word = '0;
    logic [AW-1:0] rx_addr = '0;
    logic          boot_req = 1'b0;
    logic          cpu_reset;
    logic          imem_wEn;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_loaded;
    logic          busy;
    logic          error;

    imem_boot_sequencer #(
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO),
        .HOLD_CYCLES(HC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_ready(rx_ready),
        .rx_word(rx_word),
        .rx_addr(rx_addr),
        .boot_req(boot_req),
        .cpu_reset(cpu_reset),
        .imem_wEn(imem_wEn),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .words_loaded(words_loaded),
        .busy(busy),
        .error(error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   busy_fall_cyc = 0;
    logic prev_wen = 1'b0;
    logic prev_busy = 1'b0;
    wr_t  exp_q[$];
    wr_t  load_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic wr_t mk(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe pops the oldest expected write.
    always @(negedge clock) begin
        wr_t w;
        if (!reset) begin
            if (imem_wEn) begin
                last_wr_cyc = cyc;
                check("strobe_single_cycle", {63'd0, prev_wen}, 64'd0);
                check("cpu_reset_during_write", {63'd0, cpu_reset}, 64'd1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_strobe: got write addr 0x%0h data 0x%0h, want none",
                             imem_waddr, imem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    check("write_addr", {52'd0, imem_waddr}, {52'd0, w.a});
                    check("write_data", {32'd0, imem_wdata}, {32'd0, w.d});
                end
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
        end
        prev_wen  = imem_wEn;
        prev_busy = busy;
    end

    task automatic do_reset(input string tag);
        int n;
        reset    = 1'b1;
        rx_ready = 1'b0;
        boot_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_error"}, {63'd0, error}, 64'd0);
        check({tag, "_wen"}, {63'd0, imem_wEn}, 64'd0);
        check({tag, "_words_loaded"}, {51'd0, words_loaded}, 64'd0);
        check({tag, "_waddr"}, {52'd0, imem_waddr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, imem_wdata}, 64'd0);
        n = 0;
        while (cpu_reset && n < HC + 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_hold_len"}, 64'(n), 64'(HC));
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input int hi, input int lo);
        exp_q.push_back(mk(a, d));
        rx_addr  = a;
        rx_word  = d;
        rx_ready = 1'b1;
        repeat (hi) @(negedge clock);
        rx_ready = 1'b0;
        rx_word  = $urandom;
        rx_addr  = AW'($urandom);
        repeat (lo) @(negedge clock);
    endtask

    // Reference: a load of n words ends TO cycles after its last strobe with
    // words_loaded = n; with the checksum build it errors iff n > 0 and the
    // XOR of the preceding words differs from the final word (x = XOR of all).
    task automatic finish_load(input int n, input logic [31:0] x, input bit timed, input bit wait_rel);
        int  guard;
        int  hs;
        bit  exp_err;
        guard = 0;
        while (busy && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL load_end: got busy still high after %0d cycles, want load closed", guard);
            return;
        end
        #1;
        hs = busy_fall_cyc;
        if (timed) check("timeout_latency", 64'(hs - last_wr_cyc), 64'(TO));
        check("words_loaded", {51'd0, words_loaded}, 64'(n));
        exp_err = CHK && (n > 0) && (x != 32'd0);
        check("error_flag", {63'd0, error}, {63'd0, exp_err});
        if (exp_err) begin
            repeat (HC + 20) @(negedge clock);
            check("cpu_held_in_error", {63'd0, cpu_reset}, 64'd1);
        end else if (wait_rel) begin
            guard = 0;
            while (cpu_reset && guard < HC + 40) begin
                @(negedge clock);
                guard++;
            end
            check("release_delay", 64'(cyc - hs), 64'(HC));
        end
    endtask

    task automatic run_load(input bit use_boot, input int hi_fix, input bit wait_rel);
        logic [31:0] x;
        int          n;
        int          hi;
        int          lo;
        x = '0;
        n = load_q.size();
        if (use_boot) begin
            boot_req = 1'b1;
            @(negedge clock);
            boot_req = 1'b0;
            @(negedge clock);
        end
        for (int i = 0; i < n; i++) begin
            hi = (hi_fix > 0) ? hi_fix : 1 + int'($urandom % 3);
            lo = (hi_fix > 0) ? 3 : ((hi >= 2) ? 1 + int'($urandom % 2) : 2);
            x ^= load_q[i].d;
            send_word(load_q[i].a, load_q[i].d, hi, lo);
            // boot_req mid-load must be ignored
            if (hi_fix == 0 && i + 1 < n && ($urandom % 4) == 0) begin
                boot_req = 1'b1;
                @(negedge clock);
                boot_req = 1'b0;
            end
        end
        finish_load(n, x, n > 0, wait_rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clock);
        do_reset("por");

        // Directed three-word image, 2 cycles high, 5-cycle spacing
        load_q.delete();
        load_q.push_back(mk(12'd0, 32'h0000_0013));
        load_q.push_back(mk(12'd1, 32'h0010_0093));
        load_q.push_back(mk(12'd2, 32'hDEAD_BEEF));
        run_load(1'b0, 2, 1'b1);

        // Level held high for 10 cycles is one word
        load_q.delete();
        load_q.push_back(mk(12'h5A5, 32'hCAFE_F00D));
        run_load(1'b0, 10, 1'b1);

        // Checksum-valid image opened by boot_req
        load_q.delete();
        load_q.push_back(mk(12'h010, 32'h1));
        load_q.push_back(mk(12'h011, 32'h2));
        load_q.push_back(mk(12'h012, 32'h3));
        run_load(1'b1, 2, 1'b1);

        // Same data with a bad checksum
        load_q.delete();
        load_q.push_back(mk(12'h010, 32'h1));
        load_q.push_back(mk(12'h011, 32'h2));
        load_q.push_back(mk(12'h012, 32'h4));
        run_load(1'b0, 2, 1'b0);

        // boot_req opens an empty load and clears any error
        boot_req = 1'b1;
        @(negedge clock);
        boot_req = 1'b0;
        check("boot_req_clears_error", {63'd0, error}, 64'd0);
        check("boot_req_busy", {63'd0, busy}, 64'd1);
        check("boot_req_words_cleared", {51'd0, words_loaded}, 64'd0);
        finish_load(0, 32'd0, 1'b0, 1'b1);

        // Reset between word 1 and word 2
        send_word(12'h020, 32'h1234_5678, 2, 2);
        do_reset("midload");

        // Randomized loads, some opened from HOLD before release
        for (int k = 0; k < 14; k++) begin
            n = int'($urandom % 6);
            load_q.delete();
            for (int j = 0; j < n; j++) load_q.push_back(mk(AW'($urandom), $urandom));
            run_load((n == 0) || (($urandom % 4) == 0), 0, ($urandom % 3) != 0);
        end

        repeat (5) @(negedge clock);
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_boot_sequencer.md
# imem_boot_sequencer

Sequences loading of a program image from the serial bootloader word receiver into instruction memory, and owns the CPU reset line. It holds the processor in reset while words arrive and generates single-cycle instruction-memory write strobes. When the link goes idle it closes the load, optionally checks an image checksum, and releases the CPU after a fixed hold interval. It sits between the bootloader receiver, the instruction ROM write port, and the processor reset input.

## Interface
- ADDR_WIDTH, 12, instruction-memory word-address width.
- TIMEOUT_CYCLES, 50000, idle cycles with no new word that end a load; must be ≥ 2.
- HOLD_CYCLES, 16, cycles the CPU is held in reset after reset or load completion before release; must be ≥ 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  reset; synchronous and active-high.
- rx_ready  in  1  receiver word-valid level; stays high while a word is presented.
- rx_word  in  32  received data word.
- rx_addr  in  ADDR_WIDTH  received target address.
- boot_req  in  1  one-cycle request to enter LOAD without waiting for a word.
- cpu_reset  out  1  processor reset, active-high.
- imem_wEn  out  1  instruction-memory write strobe.
- imem_waddr  out  ADDR_WIDTH  write address.
- imem_wdata  out  32  write data.
- words_loaded  out  ADDR_WIDTH+1  words accepted in the current or last load; saturates at 2^ADDR_WIDTH.
- busy  out  1  high in LOAD or WRITE.
- error  out  1  checksum failure flag; see Configuration.

## Operation
- States: HOLD, RUN, LOAD, WRITE, ERROR.
- Reset values: state HOLD, cpu_reset 1, imem_wEn 0, imem_waddr 0, imem_wdata 0, words_loaded 0, busy 0, error 0, hold/idle counters 0, rx_ready_q 0.
- New word = rx_ready high and rx_ready_q low, where rx_ready_q is rx_ready registered once. A level held high counts as one word.
- HOLD: cpu_reset 1. Count HOLD_CYCLES, then go to RUN. A new word or boot_req moves to LOAD.
- RUN: cpu_reset 0. A new word or boot_req moves to LOAD.
- LOAD: cpu_reset 1, busy 1. Idle counter increments each cycle.
  - On a new word: latch rx_word and rx_addr into imem_wdata and imem_waddr, increment words_loaded (saturating), clear the idle counter, and go to WRITE.
  - When the idle counter reaches TIMEOUT_CYCLES - 1: go to HOLD (or ERROR, see Configuration).
- WRITE: imem_wEn 1 for this single cycle, then return to LOAD. A new word detected during WRITE is captured and handled on return to LOAD; no word is dropped.
- Entering LOAD from HOLD, RUN or ERROR clears words_loaded, the idle counter, and error.
- boot_req while already in LOAD or WRITE is ignored.
- Duplicate or out-of-order addresses are written as received. No bounds check is applied because every ADDR_WIDTH value is valid.

## Timing
- Word edge sampled at rising edge N → state WRITE and imem_wEn high during cycle N+1 → low at N+2.
- Address and data are stable for the whole strobe cycle.
- cpu_reset rises in the cycle after the RUN→LOAD transition edge, before any write strobe.
- Load end: TIMEOUT_CYCLES cycles after the last word's WRITE cycle, state becomes HOLD.
- cpu_reset falls exactly HOLD_CYCLES cycles after entering HOLD.
- After reset deasserts: cpu_reset stays 1 for HOLD_CYCLES cycles, then 0.
- Reset asserted mid-load: the next edge returns all state to reset values. Any partially loaded image remains in memory.
- Minimum word spacing: 3 cycles (rx_ready must go low at least one cycle between words).

## Configuration
- BOOT_CHECKSUM_EN defined:
  - A running 32-bit XOR is kept over written words.
  - The final word of each load is treated as a checksum. It is still written to memory but excluded from the XOR.
  - At timeout, if the XOR of all preceding words does not equal the final word: go to ERROR, set error to 1, and hold cpu_reset at 1 until reset or a new load.
  - If they match: go to HOLD.
  - A load of zero words goes straight to HOLD with no error.
- BOOT_CHECKSUM_EN undefined: no XOR logic; ERROR is unreachable; error is tied to 0.

## Test plan
- Reset, HOLD_CYCLES=16, no input → cpu_reset 1 for 16 cycles after reset deassert, then 0; imem_wEn never high.
- Three words (0x00000013@0, 0x00100093@1, 0xDEADBEEF@2), rx_ready high 2 cycles each, spacing 5 cycles → exactly three single-cycle strobes with matching addr/data; cpu_reset 1 throughout; words_loaded=3.
- rx_ready held high 10 cycles → exactly one strobe.
- TIMEOUT_CYCLES=8 after last word → HOLD entered 8 cycles after WRITE; cpu_reset released 16 cycles later.
- Reset asserted between word 1 and word 2 → next cycle words_loaded=0, busy=0, cpu_reset=1, state HOLD.
- With BOOT_CHECKSUM_EN: words 0x1, 0x2, checksum 0x3 → no error, release. Same data with checksum 0x4 → error=1, cpu_reset stays 1; a new boot_req clears error.
